borrow_lookahead_serial_sub: RTL and testbench

//   Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 4-bit digit per clock, LSB digit first.

---
 rtl/borrow_lookahead_serial_sub_pkg.sv | 17 +
 rtl/borrow_lookahead_serial_sub_if.sv | 25 ++
 rtl/borrow_lookahead_serial_sub_bla4.sv | 27 ++
 rtl/borrow_lookahead_serial_sub.sv | 107 ++++++++++
 tb/tb_borrow_lookahead_serial_sub.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/borrow_lookahead_serial_sub_pkg.sv
// Shared definitions for the digit-serial borrow-lookahead subtractor.
// Optional signed-overflow output is enabled with SIGNED_OVF_EN.
package sub_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned digit_count(input int unsigned width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/borrow_lookahead_serial_sub_if.sv
// Request/result bundle for borrow_lookahead_serial_sub.
// The ovf signal exists only when SIGNED_OVF_EN is defined.
interface borrow_lookahead_serial_sub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/borrow_lookahead_serial_sub_bla4.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - bi, bo = borrow out.
// All internal borrows come straight from generate/propagate terms.
module borrow_lookahead_4bit (
  output logic [3:0] d,
  output logic       bo,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] bw;

  always_comb begin
    g     = ~x & y;
    p     = ~(x ^ y);
    bw[0] = bi;
    bw[1] = g[0] | (p[0] & bi);
    bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    bo    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bi);
    d     = x ^ y ^ bw;
  end

endmodule

// File: rtl/borrow_lookahead_serial_sub.sv
// Digit-serial subtractor diff = a - b - bin, one 4-bit digit per clock, LSB first.
// SIGNED_OVF_EN adds a registered signed-overflow flag.
module borrow_lookahead_serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  borrow_lookahead_serial_sub_if.slave bus
);

  localparam int unsigned N     = digit_count(WIDTH);
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow;
  logic               bout_r;
  logic [DIGIT_W-1:0] a_d;
  logic [DIGIT_W-1:0] b_d;
  logic [DIGIT_W-1:0] d;
  logic               bo;
`ifdef SIGNED_OVF_EN
  logic               ovf_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_d = DIGIT_W'(a_r >> (DIGIT_W * idx));
    b_d = DIGIT_W'(b_r >> (DIGIT_W * idx));
  end

  borrow_lookahead_4bit u_slice (
    .d  (d),
    .bo (bo),
    .x  (a_d),
    .y  (b_d),
    .bi (borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else if (accept) begin
      idx    <= '0;
      a_r    <= bus.a;
      b_r    <= bus.b;
      borrow <= bus.bin;
    end else if (state == RUN) begin
      diff_r[DIGIT_W*idx +: DIGIT_W] <= d;
      borrow <= bo;
      idx    <= (idx == LAST) ? '0 : idx + 1'b1;
      if (idx == LAST) begin
        bout_r <= bo;
`ifdef SIGNED_OVF_EN
        // top digit is not in diff_r yet, so its sign comes from the slice
        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d[DIGIT_W-1] != a_r[WIDTH-1]);
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
`ifdef SIGNED_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_borrow_lookahead_serial_sub.sv
// Self-checking bench for borrow_lookahead_serial_sub (WIDTH=16); honours SIGNED_OVF_EN.
module tb_borrow_lookahead_serial_sub;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  borrow_lookahead_serial_sub_if #(.WIDTH(W)) bus ();

  borrow_lookahead_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: arithmetic result plus timing derived from the accepting edge number.
  int           cyc      = 0;
  int           last_acc = -1000;
  bit           mv       = 1'b0;
  logic [W-1:0] pend_d, com_d;
  logic         pend_b, com_b, pend_o, com_o;

  always @(posedge clk) begin
    logic [W:0] t;
    int         r;
    cyc++;
    if (!rst_n) begin
      mv = 1'b1; last_acc = -1000;
      com_d = '0; com_b = 1'b0; com_o = 1'b0;
    end else if (bus.start && !((cyc - 1) >= last_acc && (cyc - 1) <= last_acc + N - 1)) begin
      last_acc = cyc;
      t = {1'b0, bus.a} - {1'b0, bus.b} - (W + 1)'(bus.bin);
      pend_d = t[W-1:0];
      pend_b = t[W];
      r = int'($signed(bus.a)) - int'($signed(bus.b)) - int'(bus.bin);
      pend_o = (r < -32768) || (r > 32767);
    end
  end

  always @(negedge clk) begin
    logic exp_busy, exp_done;
    if (mv) begin
      exp_busy = (cyc >= last_acc) && (cyc <= last_acc + N - 1);
      exp_done = (cyc == last_acc + N);
      if (exp_done) begin com_d = pend_d; com_b = pend_b; com_o = pend_o; end
      chk("model_busy", 32'(bus.busy), 32'(exp_busy));
      chk("model_done", 32'(bus.done), 32'(exp_done));
      if (!exp_busy) begin
        chk("model_diff", 32'(bus.diff), 32'(com_d));
        chk("model_bout", 32'(bus.bout), 32'(com_b));
`ifdef SIGNED_OVF_EN
        chk("model_ovf", 32'(bus.ovf), 32'(com_o));
`endif
      end
    end
  end

  task automatic run_vec(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.a = va; bus.b = vb; bus.bin = vbin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 32'(n), 32'd5);
    chk({nm, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bus.bout), 32'(eb));
`ifdef SIGNED_OVF_EN
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected unknown ovf literal");
`endif
  endtask

  initial begin
    int n, dones;
    logic [W-1:0] seen;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;

    run_vec("v1234", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    run_vec("wrap",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_vec("cross", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    run_vec("binw",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_vec("sovf",  16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run_vec("eq",    16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_vec("small", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    run_vec("povf",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // start in the 2nd RUN cycle must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0034; bus.bin = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.a = 16'hFFFF;
    @(negedge clk); bus.start = 1'b0;
    dones = 0; seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin dones++; seen = bus.diff; end
      @(negedge clk);
    end
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_diff", 32'(seen), 32'h1200);

    // back-to-back: start held through DONE
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0034; bus.bin = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_first_diff", 32'(bus.diff), 32'h1200);
    bus.a = 16'h1000; bus.b = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_spacing", 32'(n), 32'd5);
    chk("b2b_second_diff", 32'(bus.diff), 32'h0FFF);

    // reset in the 3rd RUN cycle aborts
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0034;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
